// File: rtl/axi_inst_rom_slave_pkg.sv
// Shared constants and types for the instruction ROM AXI read responder.
// Holds the AXI encodings plus the burst legality check used at AR acceptance.
package axi_inst_rom_slave_pkg;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED  = 2'b00;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] BURST_WRAP   = 2'b10;
    localparam logic [1:0] BURST_RSVD   = 2'b11;

    localparam logic [2:0] ARSIZE_4B    = 3'b010;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } rom_state_t;

    // Anything other than full-word INCR/FIXED bursts is answered with SLVERR on every beat.
    function automatic logic burst_req_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size != ARSIZE_4B) || (burst == BURST_WRAP) || (burst == BURST_RSVD);
    endfunction

endpackage

// File: rtl/axi_inst_rom_slave_if.sv
// AXI4 read-address and read-data channels between the fetch master and the ROM slave.
// Write channels are absent: the ROM is filled through the separate loader port.
interface axi_inst_rom_slave_if #(
    parameter int ID_W     = 1,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARUSER_W = 1,
    parameter int RUSER_W  = 4
);

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic [ARUSER_W-1:0] aruser;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic [RUSER_W-1:0]  ruser;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser,
        input  arvalid,
        output arready,
        output rid, rdata, rresp, rlast, ruser, rvalid,
        input  rready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser,
        output arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, ruser, rvalid,
        output rready
    );

endinterface

// File: rtl/axi_inst_rom_slave_bram.sv
// Word-wide 1R1W synchronous RAM with one cycle of read latency.
// A read and a write to the same word in one cycle return the pre-write contents.
module axi_inst_rom_slave_bram #(
    parameter int C_MEM_WORDS_LOG2 = 12
) (
    input  logic                        CLK,
    input  logic                        we,
    input  logic [C_MEM_WORDS_LOG2-1:0] waddr,
    input  logic [31:0]                 wdata,
    input  logic                        re,
    input  logic [C_MEM_WORDS_LOG2-1:0] raddr,
    output logic [31:0]                 rdata
);

    logic [31:0] mem [2**C_MEM_WORDS_LOG2];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axi_inst_rom_slave.sv
// AXI4 read-only responder for instruction fetch, one burst outstanding at a time.
// Beats are read from a word-addressed BRAM that the loader port fills before execution.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no burst in flight; ARREADY high unless RST is asserted
//   ST_BURST | issuing BRAM reads and returning R beats until RLAST handshake
module axi_inst_rom_slave
    import axi_inst_rom_slave_pkg::*;
#(
    parameter int                            C_S_AXI_THREAD_ID_WIDTH = 1,
    parameter int                            C_S_AXI_ADDR_WIDTH      = 32,
    parameter int                            C_S_AXI_DATA_WIDTH      = 32,
    parameter int                            C_S_AXI_ARUSER_WIDTH    = 1,
    parameter int                            C_S_AXI_RUSER_WIDTH     = 4,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR             = 32'h2000_0000,
    parameter int                            C_MEM_WORDS_LOG2        = 12
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        LD_WE,
    input  logic [C_MEM_WORDS_LOG2-1:0] LD_ADDR,
    input  logic [31:0]                 LD_DATA,
    axi_inst_rom_slave_if.slave         s_axi
);

    localparam int                      AW        = C_S_AXI_ADDR_WIDTH;
    localparam int                      IW        = C_S_AXI_THREAD_ID_WIDTH;
    localparam logic [AW-1:0]           MEM_BYTES = AW'(1) << (C_MEM_WORDS_LOG2 + 2);

    rom_state_t                  state;
    rom_state_t                  state_nxt;
    logic                        arready_c;

    logic [AW-1:0]               offset_q;
    logic [8:0]                  beats_q;
    logic [8:0]                  issued_q;
    logic                        burst_err_q;
    logic                        fixed_q;
    logic [IW-1:0]               rid_q;
    logic                        rvalid_q;
    logic                        rlast_q;
    logic                        rerr_q;

    logic                        ar_hs;
    logic                        r_hs;
    logic                        issue;
    logic                        in_range;
    logic                        beat_err;
    logic                        beat_last;
    logic [AW-1:0]               ar_offset;
    logic [C_MEM_WORDS_LOG2-1:0] rd_word;
    logic [31:0]                 bram_q;

    assign ar_hs     = s_axi.arvalid && arready_c;
    assign r_hs      = rvalid_q && s_axi.rready;
    assign issue     = (state == ST_BURST) && (issued_q < beats_q) && (!rvalid_q || s_axi.rready);
    assign ar_offset = s_axi.araddr - C_BASE_ADDR;

    // Offsets below the base wrap to huge unsigned values, so one compare covers both ends.
    assign in_range  = offset_q < MEM_BYTES;
    assign beat_err  = burst_err_q || !in_range;
    assign beat_last = issued_q == (beats_q - 9'd1);
    assign rd_word   = offset_q[C_MEM_WORDS_LOG2+1:2];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        arready_c = 1'b0;
        case (state)
            ST_IDLE: begin
                arready_c = !RST;
                if (ar_hs) begin
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (r_hs && rlast_q) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            offset_q    <= '0;
            beats_q     <= '0;
            issued_q    <= '0;
            burst_err_q <= 1'b0;
            fixed_q     <= 1'b0;
            rid_q       <= '0;
        end else if (ar_hs) begin
            offset_q    <= {ar_offset[AW-1:2], 2'b00};
            beats_q     <= {1'b0, s_axi.arlen} + 9'd1;
            issued_q    <= '0;
            burst_err_q <= burst_req_bad(s_axi.arsize, s_axi.arburst);
            fixed_q     <= s_axi.arburst == BURST_FIXED;
            rid_q       <= s_axi.arid;
        end else if (issue) begin
            issued_q    <= issued_q + 9'd1;
            if (!fixed_q) begin
                offset_q <= offset_q + AW'(4);
            end
        end
    end

    // Beat attributes are captured alongside the BRAM read so they line up with bram_q.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rerr_q   <= 1'b0;
        end else if (issue) begin
            rvalid_q <= 1'b1;
            rlast_q  <= beat_last;
            rerr_q   <= beat_err;
        end else if (r_hs) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
        end
    end

    axi_inst_rom_slave_bram #(
        .C_MEM_WORDS_LOG2 (C_MEM_WORDS_LOG2)
    ) u_bram (
        .CLK   (CLK),
        .we    (LD_WE),
        .waddr (LD_ADDR),
        .wdata (LD_DATA),
        .re    (issue),
        .raddr (rd_word),
        .rdata (bram_q)
    );

    assign s_axi.arready = arready_c;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.rresp   = (rvalid_q && rerr_q) ? RRESP_SLVERR : RRESP_OKAY;
    assign s_axi.rdata   = C_S_AXI_DATA_WIDTH'((rvalid_q && !rerr_q) ? bram_q : 32'd0);
    assign s_axi.ruser   = '0;

    logic unused;
    assign unused = ^{s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos, s_axi.aruser};

endmodule

// File: tb/tb_axi_inst_rom_slave.sv
// Directed and randomized bursts against the instruction ROM slave, checked beat by beat
// against a burst-level model of what the ROM should return.
module tb_axi_inst_rom_slave;

    localparam int          LOG2    = 12;
    localparam int          WORDS   = 1 << LOG2;
    localparam logic [31:0] BASE    = 32'h2000_0000;
    localparam logic [31:0] MEM_END = BASE + 32'(4 * WORDS);

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              LD_WE = 1'b0;
    logic [LOG2-1:0]   LD_ADDR = '0;
    logic [31:0]       LD_DATA = '0;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] mem_model [WORDS];

    axi_inst_rom_slave_if #(
        .ID_W(1), .ADDR_W(32), .DATA_W(32), .ARUSER_W(1), .RUSER_W(4)
    ) axi ();

    axi_inst_rom_slave #(
        .C_S_AXI_THREAD_ID_WIDTH (1),
        .C_S_AXI_ADDR_WIDTH      (32),
        .C_S_AXI_DATA_WIDTH      (32),
        .C_S_AXI_ARUSER_WIDTH    (1),
        .C_S_AXI_RUSER_WIDTH     (4),
        .C_BASE_ADDR             (BASE),
        .C_MEM_WORDS_LOG2        (LOG2)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .LD_WE   (LD_WE),
        .LD_ADDR (LD_ADDR),
        .LD_DATA (LD_DATA),
        .s_axi   (axi)
    );

    always #5 CLK = ~CLK;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input int w, input logic [31:0] v);
        @(negedge CLK);
        LD_WE   = 1'b1;
        LD_ADDR = LOG2'(w);
        LD_DATA = v;
        mem_model[w] = v;
    endtask

    // mode: 0 = RREADY always high, 1 = 1,0,0 repeating, 2 = random
    task automatic run_burst(input logic id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int mode,
                             input bit do_ld, input int ld_word, input logic [31:0] ld_val,
                             output int done_cyc);
        logic [31:0] exp_data[$];
        logic [1:0]  exp_resp[$];
        logic [31:0] a;
        logic [31:0] held_data;
        logic [1:0]  held_resp;
        logic        held_last;
        logic [31:0] bd;
        logic [1:0]  br;
        bit          bad;
        bit          first_seen;
        bit          prev_hold;
        int          cyc;
        int          pat;

        bad = (size != 3'b010) || (burst == 2'b10) || (burst == 2'b11);
        for (int i = 0; i <= int'(len); i++) begin
            a = {addr[31:2], 2'b00} + ((burst == 2'b00) ? 32'd0 : 32'(4 * i));
            if (bad || a < BASE || a >= MEM_END) begin
                exp_data.push_back(32'd0);
                exp_resp.push_back(2'b10);
            end else begin
                exp_data.push_back(mem_model[int'((a - BASE) >> 2)]);
                exp_resp.push_back(2'b00);
            end
        end

        @(negedge CLK);
        axi.arid    = id;
        axi.araddr  = addr;
        axi.arlen   = len;
        axi.arsize  = size;
        axi.arburst = burst;
        axi.arvalid = 1'b1;
        axi.rready  = 1'b0;
        cyc = 0;
        while (axi.arready !== 1'b1 && cyc < 20) begin
            @(negedge CLK);
            cyc++;
        end
        chk("ar_accept", 32'(axi.arready), 32'd1);

        @(negedge CLK);
        axi.arvalid = 1'b0;
        cyc = 1;
        chk("arready_busy", 32'(axi.arready), 32'd0);
        if (do_ld) begin
            LD_WE   = 1'b1;
            LD_ADDR = LOG2'(ld_word);
            LD_DATA = ld_val;
        end

        first_seen = 0;
        prev_hold  = 0;
        pat        = 0;
        done_cyc   = -1;
        while (exp_data.size() > 0 && cyc < 3000) begin
            if (cyc == 2) LD_WE = 1'b0;
            case (mode)
                0:       axi.rready = 1'b1;
                1:       axi.rready = (pat % 3) == 0;
                default: axi.rready = 1'($urandom_range(0, 1));
            endcase
            pat++;
            if (axi.rvalid === 1'b1) begin
                if (!first_seen) begin
                    chk("first_latency", 32'(cyc), 32'd2);
                    first_seen = 1;
                end
                if (prev_hold) begin
                    chk("hold_rdata", axi.rdata, held_data);
                    chk("hold_rresp", 32'(axi.rresp), 32'(held_resp));
                    chk("hold_rlast", 32'(axi.rlast), 32'(held_last));
                end
                if (axi.rready) begin
                    bd = exp_data.pop_front();
                    br = exp_resp.pop_front();
                    chk("rdata", axi.rdata, bd);
                    chk("rresp", 32'(axi.rresp), 32'(br));
                    chk("rlast", 32'(axi.rlast), 32'(exp_data.size() == 0));
                    chk("rid", 32'(axi.rid), 32'(id));
                    chk("ruser", 32'(axi.ruser), 32'd0);
                    prev_hold = 0;
                    done_cyc  = cyc;
                end else begin
                    prev_hold = 1;
                    held_data = axi.rdata;
                    held_resp = axi.rresp;
                    held_last = axi.rlast;
                end
            end
            @(negedge CLK);
            cyc++;
        end
        LD_WE = 1'b0;
        chk("beats_left", 32'(exp_data.size()), 32'd0);
        chk("rvalid_after", 32'(axi.rvalid), 32'd0);
        chk("arready_after", 32'(axi.arready), 32'd1);
        axi.rready = 1'b0;
        if (do_ld) mem_model[ld_word] = ld_val;
    endtask

    initial begin
        int          dc;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          r;

        axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'b010;
        axi.arburst = 2'b01; axi.arlock = '0; axi.arcache = '0; axi.arprot = '0;
        axi.arqos = '0; axi.aruser = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

        // reset values, then fill the ROM while RST is still held
        repeat (3) @(negedge CLK);
        chk("rst_rvalid", 32'(axi.rvalid), 32'd0);
        chk("rst_rlast", 32'(axi.rlast), 32'd0);
        chk("rst_rresp", 32'(axi.rresp), 32'd0);
        chk("rst_rdata", axi.rdata, 32'd0);
        chk("rst_rid", 32'(axi.rid), 32'd0);
        chk("rst_arready", 32'(axi.arready), 32'd0);
        for (int w = 0; w < WORDS; w++) begin
            load_word(w, (w < 8) ? 32'hA000_0000 + 32'(w) : $urandom);
        end
        @(negedge CLK);
        LD_WE = 1'b0;
        RST = 1'b0;
        #1;
        chk("arready_out_of_rst", 32'(axi.arready), 32'd1);

        run_burst(1'b1, 32'h2000_0000, 8'd3, 3'b010, 2'b01, 0, 0, 0, 32'd0, dc);
        chk("incr4_done_cycle", 32'(dc), 32'd5);
        run_burst(1'b1, 32'h2000_0000, 8'd3, 3'b010, 2'b01, 1, 0, 0, 32'd0, dc);
        run_burst(1'b0, 32'h2000_3FFC, 8'd1, 3'b010, 2'b01, 0, 0, 0, 32'd0, dc);
        run_burst(1'b1, 32'h2000_0000, 8'd2, 3'b001, 2'b01, 0, 0, 0, 32'd0, dc);
        run_burst(1'b0, 32'h2000_0008, 8'd2, 3'b010, 2'b00, 1, 0, 0, 32'd0, dc);
        run_burst(1'b1, 32'h2000_0010, 8'd2, 3'b010, 2'b10, 0, 0, 0, 32'd0, dc);
        run_burst(1'b0, 32'h1FFF_FFF8, 8'd3, 3'b010, 2'b01, 2, 0, 0, 32'd0, dc);

        // reset in the middle of an 8-beat burst
        @(negedge CLK);
        axi.arid = 1'b0; axi.araddr = BASE; axi.arlen = 8'd7;
        axi.arsize = 3'b010; axi.arburst = 2'b01; axi.arvalid = 1'b1; axi.rready = 1'b1;
        chk("mid_rst_ar", 32'(axi.arready), 32'd1);
        @(negedge CLK);
        axi.arvalid = 1'b0;
        @(negedge CLK);
        chk("mid_rst_beat0", axi.rdata, mem_model[0]);
        @(negedge CLK);
        chk("mid_rst_beat1", axi.rdata, mem_model[1]);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("mid_rst_rvalid", 32'(axi.rvalid), 32'd0);
        chk("mid_rst_arready", 32'(axi.arready), 32'd0);
        @(negedge CLK);
        chk("mid_rst_rvalid2", 32'(axi.rvalid), 32'd0);
        chk("mid_rst_arready2", 32'(axi.arready), 32'd0);
        RST = 1'b0;
        axi.rready = 1'b0;
        #1;
        chk("post_rst_arready", 32'(axi.arready), 32'd1);
        run_burst(1'b1, 32'h2000_000C, 8'd0, 3'b010, 2'b01, 0, 0, 0, 32'd0, dc);

        // loader write colliding with the read of the same word
        run_burst(1'b0, 32'h2000_0014, 8'd0, 3'b010, 2'b01, 0, 1, 5, 32'h5EED_0005, dc);
        run_burst(1'b0, 32'h2000_0014, 8'd0, 3'b010, 2'b01, 0, 0, 0, 32'd0, dc);
        chk("collision_model_word5", mem_model[5], 32'h5EED_0005);

        for (int n = 0; n < 30; n++) begin
            load_word($urandom_range(0, WORDS - 1), $urandom);
            @(negedge CLK);
            LD_WE = 1'b0;
            r = $urandom_range(0, 9);
            if (r < 6)
                addr = BASE + 32'(4 * $urandom_range(0, WORDS - 1)) + 32'($urandom_range(0, 3));
            else if (r < 8)
                addr = MEM_END - 32'(4 * $urandom_range(1, 8));
            else
                addr = BASE - 32'(4 * $urandom_range(1, 8));
            len   = (n == 7) ? 8'd255 : 8'($urandom_range(0, 15));
            size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            burst = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            run_burst(1'($urandom_range(0, 1)), addr, len, size, burst,
                      $urandom_range(0, 2), 0, 0, 32'd0, dc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_inst_rom_slave.md
Name: axi_inst_rom_slave

Overview:
- AXI4 read-only responder backing the instruction fetch path: accepts AR requests and returns R beats from an internal word-addressed BRAM.
- Sits on the far end of the fetch unit's AXI master port, in simulation benches and in standalone core builds.
- A simple loader write port fills the memory before EXEC is raised.

Parameters:
C_S_AXI_THREAD_ID_WIDTH, 1, ARID/RID width
C_S_AXI_ADDR_WIDTH, 32, ARADDR width
C_S_AXI_DATA_WIDTH, 32, RDATA width (only 32 supported)
C_S_AXI_ARUSER_WIDTH, 1, ARUSER width (ignored)
C_S_AXI_RUSER_WIDTH, 4, RUSER width
C_BASE_ADDR, 32'h2000_0000, byte address of word 0
C_MEM_WORDS_LOG2, 12, log2 of memory depth in 32-bit words

Ports:
CLK  in  1  clock
RST  in  1  reset (RST, synchronous, active-high; clock CLK)
LD_WE  in  1  loader write strobe
LD_ADDR  in  C_MEM_WORDS_LOG2  loader word address
LD_DATA  in  32  loader write data
S_AXI_ARID  in  ID  transaction ID
S_AXI_ARADDR  in  ADDR  burst start byte address
S_AXI_ARLEN  in  8  beats-1
S_AXI_ARSIZE  in  3  beat size
S_AXI_ARBURST  in  2  burst type
S_AXI_ARLOCK / ARCACHE / ARPROT / ARQOS / ARUSER  in  2/4/3/4/ARUSER  ignored
S_AXI_ARVALID  in  1  request valid
S_AXI_ARREADY  out  1  request accept
S_AXI_RID  out  ID  echoed ARID
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  OKAY=00, SLVERR=10
S_AXI_RLAST  out  1  final beat
S_AXI_RUSER  out  RUSER  constant 0
S_AXI_RVALID  out  1  beat valid
S_AXI_RREADY  in  1  master accepts beat

Behaviour:
- Reset values: ARREADY=0, RVALID=0, RLAST=0, RRESP=00, RDATA=0, RID=0, state IDLE. Memory contents are not cleared by reset.
- States:
  - IDLE: ARREADY=1.
  - BURST: ARREADY=0.
- Transitions:
  - IDLE->BURST on ARVALID&&ARREADY. Latch ARID, word address = (ARADDR-C_BASE_ADDR)>>2 (ARADDR[1:0] ignored, aligned down), beats = ARLEN+1, burst error flag.
  - BURST->IDLE on the cycle RLAST&&RVALID&&RREADY; ARREADY=1 the following cycle.
- Only one outstanding transaction; no back-to-back AR acceptance in the RLAST handshake cycle.
- Issue rule: a memory read is issued in cycle t iff in BURST, beats_issued<beats, and (!RVALID || RREADY). Data is registered into RDATA with RVALID=1 at t+1.
- Latency: AR handshake at cycle 0 -> first RVALID at cycle 2. With RREADY held high, throughput is 1 beat/cycle, so a 4-beat burst completes at cycle 5.
- Backpressure: RVALID&&!RREADY holds RDATA/RRESP/RLAST/RID stable and issues no read.
- Address increment: INCR +1 word per beat; FIXED holds address. Word address wraps modulo 2^C_MEM_WORDS_LOG2 only if in range (see below).
- SLVERR:
  - Whole burst: ARSIZE!=3'b010 or ARBURST==WRAP (2'b10) or reserved (2'b11). RDATA=0 on every beat, beat count still ARLEN+1, RLAST still correct.
  - Per beat: beat byte address <C_BASE_ADDR or >=C_BASE_ADDR+4*2^C_MEM_WORDS_LOG2. That beat only gets RRESP=10, RDATA=0.
- RLAST=1 exactly on beat index ARLEN (ARLEN=0 -> single beat with RLAST=1).
- Loader port:
  - LD_WE writes LD_DATA at LD_ADDR, active in any state.
  - Same-cycle read and write to the same word returns old data (read-first).
- RST mid-burst: aborts immediately. Next cycle RVALID=0, state IDLE, ARREADY=0 while RST is high. Remaining beats are never sent.

Decomposition:
- Shared package axi_defs:
  - RRESP constants OKAY/SLVERR.
  - ARBURST constants FIXED/INCR/WRAP.
  - ARSIZE_4B constant.
- Sub-module inst_rom_bram: 1R1W synchronous BRAM, read-first, 1-cycle read latency, parameter C_MEM_WORDS_LOG2.

Test Plan:
- Load words 0..7 = 32'hA000_0000+i. AR ARADDR=2000_0000, ARLEN=3, INCR, ARID=1, RREADY=1 -> RVALID cycles 2..5, RDATA A000_0000..A000_0003, RLAST on 4th beat, RID=1, RRESP=00.
- Same burst with RREADY toggling 1,0,0,1,... -> each beat held stable while RREADY=0; data order unchanged; no beat dropped or duplicated.
- ARADDR=2000_3FFC, ARLEN=1, C_MEM_WORDS_LOG2=12 -> beat0 RRESP=00 with data of word 4095; beat1 RRESP=10, RDATA=0, RLAST=1.
- ARSIZE=3'b001, ARLEN=2 -> 3 beats all RRESP=10, RDATA=0, RLAST on beat 3. ARBURST=FIXED at 2000_0008, ARLEN=2 -> three beats of A000_0002.
- RST asserted after 2nd beat of an ARLEN=7 burst -> RVALID=0 next cycle, ARREADY=0 during RST, ARREADY=1 in the cycle after RST drops. A new ARLEN=0 burst returns a single beat with RLAST=1.
- LD_WE to word 5 in the same cycle as a read issue for word 5 -> returns old value. A re-read returns the new LD_DATA.
